// File: rtl/dmem_wait.sv
// dmem_wait: word-organised data RAM behind a req/ready/rvalid handshake with
// LATENCY wait states. Byte/half/word accesses, byte-lane stores,
// sign/zero-extended loads, and a fault response for illegal accesses.
//
// Ports:
//   i_clk     clock, all state updates on the rising edge
//   i_reset   synchronous active-high reset
//   i_req     access request, taken only while o_ready=1
//   i_we      1=store, 0=load
//   i_size    00=byte, 01=half, 10=word, 11=illegal
//   i_sext    loads only: 1=sign-extend, 0=zero-extend
//   i_a       byte address
//   i_wd      store data, right-aligned
//   o_ready   a request can be accepted this cycle
//   o_rvalid  one-cycle completion pulse (load data or store ack)
//   o_rd      load result, valid with o_rvalid
//   o_fault   qualifies o_rvalid: the access was rejected
module dmem_wait #(
   parameter int unsigned DEPTH   = 64,
   parameter int unsigned LATENCY = 1
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_req,
   input  logic        i_we,
   input  logic [1:0]  i_size,
   input  logic        i_sext,
   input  logic [31:0] i_a,
   input  logic [31:0] i_wd,
   output logic        o_ready,
   output logic        o_rvalid,
   output logic [31:0] o_rd,
   output logic        o_fault
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = 4;
   localparam logic [CW-1:0] LAT_M1 = CW'((LATENCY == 0) ? 0 : LATENCY - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]    r_state;
   logic [CW-1:0] r_cnt;
   logic [31:0]   r_a;
   logic [31:0]   r_wd;
   logic          r_we;
   logic [1:0]    r_size;
   logic          r_sext;
   logic          r_ready;
   logic          r_rvalid;
   logic [31:0]   r_rd;
   logic          r_fault;
   logic [31:0]   r_mem [DEPTH];

   logic [1:0]    w_state_nxt;
   logic [CW-1:0] w_cnt_nxt;
   logic          w_accept;
   logic          w_complete;
   logic [31:0]   w_op_a;
   logic [31:0]   w_op_wd;
   logic          w_op_we;
   logic [1:0]    w_op_size;
   logic          w_op_sext;
   logic          w_fault;
   logic [AW-1:0] w_idx;
   logic [1:0]    w_lane;
   logic [31:0]   w_word;
   logic [31:0]   w_sh_byte;
   logic [31:0]   w_sh_half;
   logic [31:0]   w_load;
   logic [3:0]    w_be;
   logic [31:0]   w_wdata;

   // o_ready is registered and always equals (state != WAIT)
   assign w_accept = i_req && r_ready;

   // Next-state and wait-counter logic
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_WAIT: begin
            if (r_cnt == '0) w_state_nxt = S_RESP;
            else             w_cnt_nxt   = r_cnt - 1'b1;
         end
         default: w_state_nxt = S_IDLE;
      endcase
      if (w_accept) begin
         if (LATENCY == 0) begin
            w_state_nxt = S_RESP;
         end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = LAT_M1;
         end
      end
   end

   // The edge entering RESP performs the access
   assign w_complete = (w_state_nxt == S_RESP);

   // With no wait states the access completes on the accept edge itself,
   // so the operands come straight from the inputs
   assign w_op_a    = (LATENCY == 0) ? i_a    : r_a;
   assign w_op_wd   = (LATENCY == 0) ? i_wd   : r_wd;
   assign w_op_we   = (LATENCY == 0) ? i_we   : r_we;
   assign w_op_size = (LATENCY == 0) ? i_size : r_size;
   assign w_op_sext = (LATENCY == 0) ? i_sext : r_sext;

   // Illegal size, misalignment or out-of-range word index
   always_comb begin
      w_fault = 1'b0;
      if (w_op_size == 2'b11)                           w_fault = 1'b1;
      if ((w_op_size == 2'b01) && w_op_a[0])            w_fault = 1'b1;
      if ((w_op_size == 2'b10) && (w_op_a[1:0] != 2'b00)) w_fault = 1'b1;
      if (w_op_a[31:2] >= 30'(DEPTH))                   w_fault = 1'b1;
   end

   assign w_idx  = w_op_a[AW+1:2];
   assign w_lane = w_op_a[1:0];
   assign w_word = r_mem[w_idx];

   // Load extraction and extension
   assign w_sh_byte = w_word >> {w_lane, 3'b000};
   assign w_sh_half = w_word >> {w_op_a[1], 4'b0000};

   always_comb begin
      w_load = w_word;
      case (w_op_size)
         2'b00:   w_load = {{24{w_op_sext & w_sh_byte[7]}},  w_sh_byte[7:0]};
         2'b01:   w_load = {{16{w_op_sext & w_sh_half[15]}}, w_sh_half[15:0]};
         default: w_load = w_word;
      endcase
   end

   // Store lane enables and replicated write data
   always_comb begin
      w_be    = 4'b0000;
      w_wdata = w_op_wd;
      case (w_op_size)
         2'b00: begin
            w_be    = 4'b0001 << w_lane;
            w_wdata = {4{w_op_wd[7:0]}};
         end
         2'b01: begin
            w_be    = w_op_a[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{w_op_wd[15:0]}};
         end
         2'b10: begin
            w_be    = 4'b1111;
            w_wdata = w_op_wd;
         end
         default: begin
            w_be    = 4'b0000;
            w_wdata = w_op_wd;
         end
      endcase
   end

   // State register, request capture and registered outputs
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_a      <= '0;
         r_wd     <= '0;
         r_we     <= 1'b0;
         r_size   <= 2'b00;
         r_sext   <= 1'b0;
         r_ready  <= 1'b1;
         r_rvalid <= 1'b0;
         r_rd     <= '0;
         r_fault  <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_ready  <= (w_state_nxt != S_WAIT);
         r_rvalid <= w_complete;
         r_fault  <= w_complete && w_fault;
         r_rd     <= (w_complete && !w_fault && !w_op_we) ? w_load : 32'd0;
         if (w_accept) begin
            r_a    <= i_a;
            r_wd   <= i_wd;
            r_we   <= i_we;
            r_size <= i_size;
            r_sext <= i_sext;
         end
      end
   end

   // RAM write; reset on the completion edge discards the store
   always_ff @(posedge i_clk) begin
      if (!i_reset && w_complete && w_op_we && !w_fault) begin
         for (int b = 0; b < 4; b++) begin
            if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
         end
      end
   end

   assign o_ready  = r_ready;
   assign o_rvalid = r_rvalid;
   assign o_rd     = r_rd;
   assign o_fault  = r_fault;

endmodule

// File: tb/tb_dmem_wait.sv
// Testbench for dmem_wait: three instances (LATENCY 0, 1, 3) checked against a
// byte-array reference model, with directed and random accesses.
module tb_dmem_wait;

   localparam int unsigned DEPTH = 64;
   localparam int NBYTES = DEPTH * 4;

   logic        clk = 1'b0;
   logic        rst    [3];
   logic        req    [3];
   logic        we     [3];
   logic [1:0]  size   [3];
   logic        sext   [3];
   logic [31:0] a      [3];
   logic [31:0] wd     [3];
   logic        ready  [3];
   logic        rvalid [3];
   logic [31:0] rd     [3];
   logic        fault  [3];

   int total = 0;
   int bad   = 0;
   int lat_of [3] = '{0, 1, 3};
   logic [7:0] mem_m [3][NBYTES];

   always #5 clk = ~clk;

   dmem_wait #(.DEPTH(DEPTH), .LATENCY(0)) u_l0 (
      .i_clk(clk), .i_reset(rst[0]), .i_req(req[0]), .i_we(we[0]),
      .i_size(size[0]), .i_sext(sext[0]), .i_a(a[0]), .i_wd(wd[0]),
      .o_ready(ready[0]), .o_rvalid(rvalid[0]), .o_rd(rd[0]), .o_fault(fault[0]));

   dmem_wait #(.DEPTH(DEPTH), .LATENCY(1)) u_l1 (
      .i_clk(clk), .i_reset(rst[1]), .i_req(req[1]), .i_we(we[1]),
      .i_size(size[1]), .i_sext(sext[1]), .i_a(a[1]), .i_wd(wd[1]),
      .o_ready(ready[1]), .o_rvalid(rvalid[1]), .o_rd(rd[1]), .o_fault(fault[1]));

   dmem_wait #(.DEPTH(DEPTH), .LATENCY(3)) u_l3 (
      .i_clk(clk), .i_reset(rst[2]), .i_req(req[2]), .i_we(we[2]),
      .i_size(size[2]), .i_sext(sext[2]), .i_a(a[2]), .i_wd(wd[2]),
      .o_ready(ready[2]), .o_rvalid(rvalid[2]), .o_rd(rd[2]), .o_fault(fault[2]));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Reference model: memory as a flat little-endian byte array
   function automatic void model(input int k, input logic mwe, input logic [1:0] msize,
                                 input logic msext, input logic [31:0] ma, input logic [31:0] mwd,
                                 output logic [31:0] mrd, output logic mf);
      int nb;
      logic [31:0] val;
      nb  = 1 << msize;
      mf  = (msize == 2'b11) || ((ma % 32'(nb)) != 0) || ((ma >> 2) >= 32'(DEPTH));
      mrd = 32'd0;
      if (mf) return;
      if (mwe) begin
         for (int i = 0; i < nb; i++) mem_m[k][int'(ma) + i] = mwd[8*i +: 8];
      end else begin
         val = 32'd0;
         for (int i = 0; i < nb; i++) val = val | (32'(mem_m[k][int'(ma) + i]) << (8*i));
         if (msext && nb < 4 && val[8*nb-1]) val = val | (32'hFFFF_FFFF << (8*nb));
         mrd = val;
      end
   endfunction

   // One handshake: wait for ready, issue, check timing and result
   task automatic do_access(input int k, input logic twe, input logic [1:0] tsize,
                            input logic tsext, input logic [31:0] ta, input logic [31:0] twd,
                            output logic [31:0] ord, output logic of);
      logic [31:0] erd;
      logic ef;
      int w;
      w = 0;
      while (!ready[k] && w < 50) begin @(negedge clk); w++; end
      chk($sformatf("ready_before_req[%0d]", k), 32'(ready[k]), 32'd1);
      req[k] = 1'b1; we[k] = twe; size[k] = tsize; sext[k] = tsext; a[k] = ta; wd[k] = twd;
      model(k, twe, tsize, tsext, ta, twd, erd, ef);
      @(posedge clk);
      @(negedge clk);
      req[k] = 1'b0;
      for (int n = 1; n <= lat_of[k]; n++) begin
         chk($sformatf("rvalid_early[%0d]", k), 32'(rvalid[k]), 32'd0);
         chk($sformatf("ready_in_wait[%0d]", k), 32'(ready[k]), 32'd0);
         @(negedge clk);
      end
      chk($sformatf("rvalid[%0d] a=%h", k, ta), 32'(rvalid[k]), 32'd1);
      chk($sformatf("rd[%0d] a=%h", k, ta), rd[k], erd);
      chk($sformatf("fault[%0d] a=%h", k, ta), 32'(fault[k]), 32'(ef));
      chk($sformatf("ready_in_resp[%0d]", k), 32'(ready[k]), 32'd1);
      ord = rd[k];
      of  = fault[k];
      @(negedge clk);
      chk($sformatf("rvalid_pulse_end[%0d]", k), 32'(rvalid[k]), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] r;
      logic f;
      logic [31:0] erd;
      logic ef;
      logic [31:0] ra;
      logic [1:0] rs;

      for (int k = 0; k < 3; k++) begin
         rst[k] = 1'b1; req[k] = 1'b0; we[k] = 1'b0; size[k] = 2'b00;
         sext[k] = 1'b0; a[k] = 32'd0; wd[k] = 32'd0;
         for (int i = 0; i < NBYTES; i++) mem_m[k][i] = 8'h00;
      end

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("reset_ready[%0d]", k), 32'(ready[k]), 32'd1);
         chk($sformatf("reset_rvalid[%0d]", k), 32'(rvalid[k]), 32'd0);
         chk($sformatf("reset_rd[%0d]", k), rd[k], 32'd0);
         chk($sformatf("reset_fault[%0d]", k), 32'(fault[k]), 32'd0);
         rst[k] = 1'b0;
      end
      @(negedge clk);

      // Directed sequence, LATENCY=1
      do_access(1, 1'b1, 2'b10, 1'b0, 32'h8, 32'h1122_3344, r, f);
      chk("sw_ack_rd", r, 32'd0);
      do_access(1, 1'b0, 2'b10, 1'b0, 32'h8, 32'h0, r, f);
      chk("lw_8", r, 32'h1122_3344);
      do_access(1, 1'b1, 2'b00, 1'b0, 32'h9, 32'hAA, r, f);
      do_access(1, 1'b0, 2'b10, 1'b0, 32'h8, 32'h0, r, f);
      chk("lw_8_after_sb", r, 32'h1122_AA44);
      do_access(1, 1'b0, 2'b00, 1'b1, 32'h9, 32'h0, r, f);
      chk("lb_9", r, 32'hFFFF_FFAA);
      do_access(1, 1'b0, 2'b00, 1'b0, 32'h9, 32'h0, r, f);
      chk("lbu_9", r, 32'h0000_00AA);
      do_access(1, 1'b1, 2'b01, 1'b0, 32'hA, 32'h8001, r, f);
      do_access(1, 1'b0, 2'b01, 1'b1, 32'hA, 32'h0, r, f);
      chk("lh_A", r, 32'hFFFF_8001);
      do_access(1, 1'b0, 2'b01, 1'b0, 32'hA, 32'h0, r, f);
      chk("lhu_A", r, 32'h0000_8001);
      do_access(1, 1'b0, 2'b10, 1'b0, 32'h8, 32'h0, r, f);
      chk("lw_8_after_sh", r, 32'h8001_AA44);

      // Illegal accesses
      do_access(1, 1'b0, 2'b10, 1'b0, 32'h6, 32'h0, r, f);
      chk("lw_6_fault", 32'(f), 32'd1);
      chk("lw_6_rd", r, 32'd0);
      do_access(1, 1'b1, 2'b01, 1'b0, 32'h5, 32'hFFFF, r, f);
      chk("sh_5_fault", 32'(f), 32'd1);
      do_access(1, 1'b0, 2'b10, 1'b0, 32'h4, 32'h0, r, f);
      chk("lw_4_unchanged", r, 32'h0);
      do_access(1, 1'b0, 2'b10, 1'b0, 32'h8, 32'h0, r, f);
      chk("lw_8_unchanged", r, 32'h8001_AA44);
      do_access(1, 1'b0, 2'b10, 1'b0, 32'(4 * DEPTH), 32'h0, r, f);
      chk("lw_oob_fault", 32'(f), 32'd1);
      do_access(1, 1'b0, 2'b11, 1'b0, 32'h0, 32'h0, r, f);
      chk("size11_fault", 32'(f), 32'd1);

      // LATENCY=0: seed four words, then stream four loads with req held high
      for (int i = 0; i < 4; i++)
         do_access(0, 1'b1, 2'b10, 1'b0, 32'(4 * i), $urandom, r, f);
      chk("stream_ready_pre", 32'(ready[0]), 32'd1);
      req[0] = 1'b1; we[0] = 1'b0; size[0] = 2'b10; sext[0] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         a[0] = 32'(4 * i);
         model(0, 1'b0, 2'b10, 1'b0, a[0], 32'h0, erd, ef);
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("stream_rvalid_%0d", i), 32'(rvalid[0]), 32'd1);
         chk($sformatf("stream_rd_%0d", i), rd[0], erd);
         chk($sformatf("stream_ready_%0d", i), 32'(ready[0]), 32'd1);
      end
      req[0] = 1'b0;
      @(negedge clk);
      chk("stream_end_rvalid", 32'(rvalid[0]), 32'd0);

      // LATENCY=3: reset two cycles after accepting a store
      req[2] = 1'b1; we[2] = 1'b1; size[2] = 2'b10; sext[2] = 1'b0;
      a[2] = 32'h10; wd[2] = 32'hDEAD_BEEF;
      @(posedge clk);
      @(negedge clk);
      req[2] = 1'b0;
      @(negedge clk);
      rst[2] = 1'b1;
      @(negedge clk);
      rst[2] = 1'b0;
      for (int n = 0; n < 5; n++) begin
         chk($sformatf("rst_mid_rvalid_%0d", n), 32'(rvalid[2]), 32'd0);
         chk($sformatf("rst_mid_ready_%0d", n), 32'(ready[2]), 32'd1);
         @(negedge clk);
      end
      do_access(2, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, r, f);
      chk("lw_10_after_reset", r, 32'h0);

      // Random accesses on every instance
      for (int i = 0; i < 90; i++) begin
         int k;
         k  = i % 3;
         rs = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
         ra = 32'($urandom_range(0, 4 * DEPTH + 15));
         if ($urandom_range(0, 9) < 7 && rs != 2'b11) ra = ra & ~((32'd1 << rs) - 32'd1);
         do_access(k, 1'($urandom_range(0, 1)), rs, 1'($urandom_range(0, 1)),
                   ra, $urandom, r, f);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
